// File: rtl/cond_pkg.sv
// Shared types for the condition unit: ARM condition codes and the NZCV flag layout.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU-to-datapath bundle around the condition unit; master drives the instruction side.
interface cond_unit_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             stall;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic [3:0]       alu_flags;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic             cond_ex;
  logic             out_valid;
  logic             pc_src;
  logic             reg_write;
  logic             mem_write;
  logic [3:0]       flags;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  modport master (
    output in_valid, stall, cond, flag_w, alu_flags, pcs, reg_w, mem_w, no_write,
    input  cond_ex, out_valid, pc_src, reg_write, mem_write, flags, exec_count, skip_count
  );

  modport slave (
    input  in_valid, stall, cond, flag_w, alu_flags, pcs, reg_w, mem_w, no_write,
    output cond_ex, out_valid, pc_src, reg_write, mem_write, flags, exec_count, skip_count
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition-field evaluation against a stored NZCV flag set.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  // condition-code decode
  always_comb begin
    cond_ex = 1'b1;
    case (cond_e'(cond))
      EQ:      cond_ex = flags.z;
      NE:      cond_ex = ~flags.z;
      CS:      cond_ex = flags.c;
      CC:      cond_ex = ~flags.c;
      MI:      cond_ex = flags.n;
      PL:      cond_ex = ~flags.n;
      VS:      cond_ex = flags.v;
      VC:      cond_ex = ~flags.v;
      HI:      cond_ex = flags.c & ~flags.z;
      LS:      cond_ex = ~flags.c | flags.z;
      GE:      cond_ex = (flags.n == flags.v);
      LT:      cond_ex = (flags.n != flags.v);
      GT:      cond_ex = ~flags.z & (flags.n == flags.v);
      LE:      cond_ex = flags.z | (flags.n != flags.v);
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural flag register, conditional gating of write strobes with one
// registered output stage, and saturating executed/skipped instruction counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  cond_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  flags_t           flags_r;
  flags_t           flags_nxt_s;
  flags_t           alu_s;
  logic             cond_ex_s;
  logic             accept_s;
  logic             out_valid_r;
  logic             pc_src_r;
  logic             reg_write_r;
  logic             mem_write_r;
  logic [CNT_W-1:0] exec_r;
  logic [CNT_W-1:0] skip_r;
  logic [CNT_W-1:0] exec_nxt_s;
  logic [CNT_W-1:0] skip_nxt_s;

  // Conditions always look at the stored flags, so back-to-back instructions see the
  // flags written at the previous edge, never the current ALU result.
  cond_eval u_eval (
    .cond    (bus.cond),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  assign accept_s = bus.in_valid & ~bus.stall;
  assign alu_s    = flags_t'(bus.alu_flags);

  // next flag value: N/Z and C/V halves update independently
  always_comb begin
    flags_nxt_s = flags_r;
    if (accept_s && cond_ex_s) begin
      if (bus.flag_w[1]) begin
        flags_nxt_s.n = alu_s.n;
        flags_nxt_s.z = alu_s.z;
      end else begin
        flags_nxt_s.n = flags_r.n;
        flags_nxt_s.z = flags_r.z;
      end
      if (bus.flag_w[0]) begin
        flags_nxt_s.c = alu_s.c;
        flags_nxt_s.v = alu_s.v;
      end else begin
        flags_nxt_s.c = flags_r.c;
        flags_nxt_s.v = flags_r.v;
      end
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // next counter values, saturating at all-ones
  always_comb begin
    exec_nxt_s = exec_r;
    skip_nxt_s = skip_r;
    if (accept_s) begin
      if (cond_ex_s) begin
        exec_nxt_s = (exec_r == CNT_MAX) ? exec_r : exec_r + CNT_ONE;
      end else begin
        skip_nxt_s = (skip_r == CNT_MAX) ? skip_r : skip_r + CNT_ONE;
      end
    end else begin
      exec_nxt_s = exec_r;
      skip_nxt_s = skip_r;
    end
  end

  // flag register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= flags_t'(4'b0000);
      exec_r  <= {CNT_W{1'b0}};
      skip_r  <= {CNT_W{1'b0}};
    end else begin
      flags_r <= flags_nxt_s;
      exec_r  <= exec_nxt_s;
      skip_r  <= skip_nxt_s;
    end
  end

  // registered output stage, frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      pc_src_r    <= 1'b0;
      reg_write_r <= 1'b0;
      mem_write_r <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_r <= bus.in_valid;
      pc_src_r    <= bus.in_valid & cond_ex_s & bus.pcs;
      reg_write_r <= bus.in_valid & cond_ex_s & bus.reg_w & ~bus.no_write;
      mem_write_r <= bus.in_valid & cond_ex_s & bus.mem_w;
    end else begin
      out_valid_r <= out_valid_r;
      pc_src_r    <= pc_src_r;
      reg_write_r <= reg_write_r;
      mem_write_r <= mem_write_r;
    end
  end

  assign bus.cond_ex    = cond_ex_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.pc_src     = pc_src_r;
  assign bus.reg_write  = reg_write_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.flags      = flags_r;
  assign bus.exec_count = exec_r;
  assign bus.skip_count = skip_r;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: driver pushes per-cycle expectations from a behavioural model,
// a negedge monitor pops and compares.
module tb_cond_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cond_unit_if #(.CNT_W(CNT_W)) bus ();
  cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int ce;
    int strobes;
    int fl;
    int ex;
    int sk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model state
  int m_flags, m_ov, m_pc, m_rw, m_mw, m_exec, m_skip;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int m_eval(input int c, input int f);
    int n, z, cf, v, base;
    n  = (f >> 3) & 1;
    z  = (f >> 2) & 1;
    cf = (f >> 1) & 1;
    v  = f & 1;
    case (c >> 1)
      0: base = z;
      1: base = cf;
      2: base = n;
      3: base = v;
      4: base = (cf == 1 && z == 0) ? 1 : 0;
      5: base = (n == v) ? 1 : 0;
      6: base = (z == 0 && n == v) ? 1 : 0;
      default: base = 1;
    endcase
    if (c == 15) return 1;
    return base ^ (c & 1);
  endfunction

  task automatic m_reset();
    m_flags = 0; m_ov = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_exec = 0; m_skip = 0;
  endtask

  // One clock cycle: apply inputs after the edge, record expectations, advance the model.
  task automatic cycle(input int v, input int st, input int c, input int fw, input int alu,
                       input int p, input int r, input int m, input int nw);
    exp_t e;
    int ce;
    @(posedge clk);
    #1;
    bus.in_valid = v[0]; bus.stall = st[0]; bus.cond = c[3:0]; bus.flag_w = fw[1:0];
    bus.alu_flags = alu[3:0]; bus.pcs = p[0]; bus.reg_w = r[0]; bus.mem_w = m[0];
    bus.no_write = nw[0];
    ce = m_eval(c, m_flags);
    e.ce = ce;
    e.strobes = (m_ov << 3) | (m_pc << 2) | (m_rw << 1) | m_mw;
    e.fl = m_flags; e.ex = m_exec; e.sk = m_skip;
    q.push_back(e);
    if (st == 0) begin
      if (v != 0) begin
        if (ce != 0) begin
          if ((fw & 2) != 0) m_flags = (m_flags & 3) | (alu & 12);
          if ((fw & 1) != 0) m_flags = (m_flags & 12) | (alu & 3);
          if (m_exec < CNT_MAX) m_exec++;
        end else begin
          if (m_skip < CNT_MAX) m_skip++;
        end
      end
      m_ov = v;
      m_pc = v & ce & p;
      m_rw = v & ce & r & (1 - nw);
      m_mw = v & ce & m;
    end
  endtask

  task automatic rand_cycle(input int st);
    cycle(($urandom_range(0, 3) != 0) ? 1 : 0, st, $urandom_range(0, 15), $urandom_range(0, 3),
          $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0; bus.stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_flags", int'(bus.flags), 0);
    chk("rst_strobes", int'({bus.out_valid, bus.pc_src, bus.reg_write, bus.mem_write}), 0);
    chk("rst_exec", int'(bus.exec_count), 0);
    chk("rst_skip", int'(bus.skip_count), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    m_reset();
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cond_ex", int'(bus.cond_ex), e.ce);
        chk("strobes", int'({bus.out_valid, bus.pc_src, bus.reg_write, bus.mem_write}), e.strobes);
        chk("flags", int'(bus.flags), e.fl);
        chk("exec_count", int'(bus.exec_count), e.ex);
        chk("skip_count", int'(bus.skip_count), e.sk);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.cond = 4'h0; bus.flag_w = 2'b00;
    bus.alu_flags = 4'h0; bus.pcs = 1'b0; bus.reg_w = 1'b0; bus.mem_w = 1'b0;
    bus.no_write = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0);

    // randomized traffic with occasional stalls
    for (int i = 0; i < 300; i++) rand_cycle(($urandom_range(0, 4) == 0) ? 1 : 0);

    // reset while flags are all ones
    cycle(1, 0, 14, 3, 15, 0, 0, 0, 0);
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0);
    do_reset();

    // every condition against every stored flag value
    for (int f = 0; f < 16; f++) begin
      cycle(1, 0, 14, 3, f, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++)
        cycle(1, 0, c, 0, $urandom_range(0, 15), 1, 1, 1, 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // N/Z-only update then EQ sees the new Z
    do_reset();
    cycle(1, 0, 14, 2, 7, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // NE with Z set: skipped, strobes suppressed, flags hold
    do_reset();
    cycle(1, 0, 14, 3, 4, 0, 0, 0, 0);
    cycle(1, 0, 1, 3, 15, 1, 1, 1, 0);
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0);

    // compare-type op, then a 3-cycle stall
    cycle(1, 0, 14, 3, 10, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) rand_cycle(1);
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 0, 14, 0, 0, 1, 1, 1, 0);
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
